ccu_ctrl_snoop_collector: RTL and testbench

CCU_CTRL_SNOOP_COLLECTOR -- requirements
Module: ccu_ctrl_snoop_collector

---
 rtl/ccu_ctrl_snoop_collector.sv | 197 +++++++++++++++++++
 tb/tb_ccu_ctrl_snoop_collector.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_ctrl_snoop_collector.sv
// Snoop-round collector: gathers CR responses from the snooped master ports,
// publishes the aggregated result, then forwards one port's CD cacheline while
// draining the CD beats of every other port that also offered data.
// The CD payload type must place its `last` flag in the least-significant bit,
// which is the case for a packed struct whose final field is `last`.
module ccu_ctrl_snoop_collector #(
    parameter int unsigned NoMstPorts      = 4,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned DcacheLineWidth = 128,
    parameter type         snoop_cd_t      = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_valid_i,
    output logic                       start_ready_o,
    input  logic [NoMstPorts-1:0]      snoop_mask_i,
    input  logic [NoMstPorts-1:0]      cr_valid_i,
    output logic [NoMstPorts-1:0]      cr_ready_o,
    input  logic [NoMstPorts-1:0][4:0] cr_resp_i,
    input  logic [NoMstPorts-1:0]      cd_valid_i,
    output logic [NoMstPorts-1:0]      cd_ready_o,
    input  snoop_cd_t [NoMstPorts-1:0] cd_i,
    output snoop_cd_t                  cd_o,
    output logic                       cd_handshake_o,
    input  logic                       cd_fifo_full_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic                       data_avail_o,
    output logic                       shared_o,
    output logic                       dirty_o,
    output logic                       error_o
);

    localparam int unsigned BeatsPerLine = DcacheLineWidth / AxiDataWidth;
    localparam int unsigned CntW         = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
    localparam int unsigned IdxW         = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
    localparam int unsigned CdW          = $bits(snoop_cd_t);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COLLECT_CR  = 2'd1,
        SEND_RESULT = 2'd2,
        FORWARD_CD  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [NoMstPorts-1:0]   mask_q, rcvd_q, dt_q, ok_q, drain_q, drain_done_q;
    logic [IdxW-1:0]         sel_q;
    logic                    sel_done_q;
    logic [CntW-1:0]         beat_cnt_q;

    logic [NoMstPorts-1:0]   cr_hs, rcvd_nxt, dt_nxt, ok_nxt, drain_nxt;
    logic [NoMstPorts-1:0]   cd_hs, cd_last, drain_done_nxt;
    logic [NoMstPorts-1:0][CdW-1:0] cd_flat;
    logic [IdxW-1:0]         sel_nxt;
    logic                    found_nxt, err_nxt, dirty_nxt, shared_nxt;
    logic                    sel_active, sel_done_nxt;
    logic                    unused_sig;

    // State-decoded handshake outputs
    assign start_ready_o  = (state_q == IDLE);
    assign result_valid_o = (state_q == SEND_RESULT);
    assign cr_ready_o     = (state_q == COLLECT_CR) ? (mask_q & ~rcvd_q) : '0;
    assign cr_hs          = cr_valid_i & cr_ready_o;
    assign rcvd_nxt       = rcvd_q | cr_hs;

    // Fold this cycle's CR handshakes into the per-port and aggregate flags
    always_comb begin
        dt_nxt     = dt_q;
        ok_nxt     = ok_q;
        err_nxt    = error_o;
        dirty_nxt  = dirty_o;
        shared_nxt = shared_o;
        for (int i = 0; i < NoMstPorts; i++) begin
            if (cr_hs[i]) begin
                dt_nxt[i]  = cr_resp_i[i][0];
                ok_nxt[i]  = cr_resp_i[i][0] & ~cr_resp_i[i][1];
                err_nxt    = err_nxt | cr_resp_i[i][1];
                dirty_nxt  = dirty_nxt | cr_resp_i[i][2];
                shared_nxt = shared_nxt | cr_resp_i[i][3];
            end
        end
    end

    // Lowest-index clean data port becomes the forwarded source; other data ports drain
    always_comb begin
        sel_nxt   = '0;
        found_nxt = 1'b0;
        for (int i = NoMstPorts - 1; i >= 0; i--) begin
            if (ok_nxt[i]) begin
                sel_nxt   = IdxW'(i);
                found_nxt = 1'b1;
            end
        end
        drain_nxt = found_nxt ? (dt_nxt & ~(NoMstPorts'(1) << sel_nxt)) : dt_nxt;
    end

    // CD routing: selected port gated by FIFO space, drain ports always accepted
    assign cd_flat    = cd_i;
    assign sel_active = (state_q == FORWARD_CD) && data_avail_o && !sel_done_q;

    always_comb begin
        cd_ready_o = '0;
        if (state_q == FORWARD_CD) begin
            cd_ready_o = drain_q & ~drain_done_q;
            if (sel_active) begin
                cd_ready_o[sel_q] = ~cd_fifo_full_i;
            end
        end
        for (int i = 0; i < NoMstPorts; i++) begin
            cd_last[i] = cd_flat[i][0];
        end
    end

    assign cd_hs          = cd_valid_i & cd_ready_o;
    assign cd_handshake_o = sel_active & cd_hs[sel_q];
    assign cd_o           = sel_active ? cd_i[sel_q] : '0;
    assign sel_done_nxt   = sel_done_q | (cd_handshake_o & cd_last[sel_q]);
    assign drain_done_nxt = drain_done_q | (cd_hs & cd_last & drain_q);

    // Payload bits, WasUnique and the line-beat count have no consumer here
    assign unused_sig = ^{beat_cnt_q, cr_resp_i, cd_flat};

    // Round sequencing and all held state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            rcvd_q       <= '0;
            dt_q         <= '0;
            ok_q         <= '0;
            drain_q      <= '0;
            drain_done_q <= '0;
            sel_q        <= '0;
            sel_done_q   <= 1'b0;
            beat_cnt_q   <= '0;
            data_avail_o <= 1'b0;
            shared_o     <= 1'b0;
            dirty_o      <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        mask_q       <= snoop_mask_i;
                        rcvd_q       <= '0;
                        dt_q         <= '0;
                        ok_q         <= '0;
                        drain_q      <= '0;
                        sel_q        <= '0;
                        beat_cnt_q   <= '0;
                        data_avail_o <= 1'b0;
                        shared_o     <= 1'b0;
                        dirty_o      <= 1'b0;
                        error_o      <= 1'b0;
                        state_q      <= COLLECT_CR;
                    end
                end
                COLLECT_CR: begin
                    rcvd_q   <= rcvd_nxt;
                    dt_q     <= dt_nxt;
                    ok_q     <= ok_nxt;
                    error_o  <= err_nxt;
                    dirty_o  <= dirty_nxt;
                    shared_o <= shared_nxt;
                    if (rcvd_nxt == mask_q) begin
                        sel_q        <= sel_nxt;
                        data_avail_o <= found_nxt;
                        drain_q      <= drain_nxt;
                        state_q      <= SEND_RESULT;
                    end
                end
                SEND_RESULT: begin
                    if (result_ready_i) begin
                        sel_done_q   <= ~data_avail_o;
                        drain_done_q <= '0;
                        beat_cnt_q   <= '0;
                        state_q      <= (data_avail_o || (|drain_q)) ? FORWARD_CD : IDLE;
                    end
                end
                FORWARD_CD: begin
                    sel_done_q   <= sel_done_nxt;
                    drain_done_q <= drain_done_nxt;
                    if (cd_handshake_o) begin
                        beat_cnt_q <= (beat_cnt_q == CntW'(BeatsPerLine - 1)) ? '0
                                                                              : beat_cnt_q + CntW'(1);
                    end
                    if (sel_done_nxt && ((drain_done_nxt & drain_q) == drain_q)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// Directed bench for the snoop collector: one linear sequence of snoop rounds,
// each step checked against hand-computed values.
module tb_ccu_ctrl_snoop_collector;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            start_valid_i = 1'b0;
    logic            start_ready_o;
    logic [3:0]      snoop_mask_i = '0;
    logic [3:0]      cr_valid_i = '0;
    logic [3:0]      cr_ready_o;
    logic [3:0][4:0] cr_resp_i = '0;
    logic [3:0]      cd_valid_i = '0;
    logic [3:0]      cd_ready_o;
    cd_t  [3:0]      cd_i = '0;
    cd_t             cd_o;
    logic            cd_handshake_o;
    logic            cd_fifo_full_i = 1'b0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic            data_avail_o, shared_o, dirty_o, error_o;

    int total = 0;
    int bad   = 0;

    ccu_ctrl_snoop_collector #(
        .NoMstPorts     (4),
        .AxiDataWidth   (64),
        .DcacheLineWidth(128),
        .snoop_cd_t     (cd_t)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .snoop_mask_i  (snoop_mask_i),
        .cr_valid_i    (cr_valid_i),
        .cr_ready_o    (cr_ready_o),
        .cr_resp_i     (cr_resp_i),
        .cd_valid_i    (cd_valid_i),
        .cd_ready_o    (cd_ready_o),
        .cd_i          (cd_i),
        .cd_o          (cd_o),
        .cd_handshake_o(cd_handshake_o),
        .cd_fifo_full_i(cd_fifo_full_i),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .data_avail_o  (data_avail_o),
        .shared_o      (shared_o),
        .dirty_o       (dirty_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land clear of the edge
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic start_round(input logic [3:0] mask);
        start_valid_i = 1'b1;
        snoop_mask_i  = mask;
        tick();
        start_valid_i = 1'b0;
        snoop_mask_i  = '0;
    endtask

    initial begin
        // Reset behaviour
        #1 rst_ni = 1'b0;
        tick();
        chk("rst_start_ready", 64'(start_ready_o), 64'd1);
        chk("rst_result_valid", 64'(result_valid_o), 64'd0);
        chk("rst_cr_ready", 64'(cr_ready_o), 64'd0);
        chk("rst_cd_ready", 64'(cd_ready_o), 64'd0);
        chk("rst_outs", 64'({cd_handshake_o, data_avail_o, shared_o, dirty_o, error_o}), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Round A: mask 0110, port1 no data, port2 shared data, two beats forwarded
        start_round(4'b0110);
        chk("A_start_ready_busy", 64'(start_ready_o), 64'd0);
        cr_valid_i   = 4'b1011;
        cr_resp_i[1] = 5'b00000;
        #1;
        chk("A_cr_ready_masked", 64'(cr_ready_o), 64'b0110);
        tick();
        chk("A_cr_ready_left", 64'(cr_ready_o), 64'b0100);
        cr_valid_i   = 4'b0100;
        cr_resp_i[2] = 5'b01001;
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        chk("A_result_valid", 64'(result_valid_o), 64'd1);
        chk("A_result", 64'({data_avail_o, shared_o, dirty_o, error_o}), 64'b1100);
        chk("A_cr_ready_off", 64'(cr_ready_o), 64'd0);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        chk("A_cd_ready", 64'(cd_ready_o), 64'b0100);
        cd_valid_i = 4'b0100;
        cd_i[2]    = '{data: 64'hA1, last: 1'b0};
        #1;
        chk("A_push1", 64'(cd_handshake_o), 64'd1);
        chk("A_data1", cd_o.data, 64'hA1);
        tick();
        cd_i[2] = '{data: 64'hA2, last: 1'b1};
        #1;
        chk("A_push2", 64'(cd_handshake_o), 64'd1);
        chk("A_data2", cd_o.data, 64'hA2);
        chk("A_last2", 64'(cd_o.last), 64'd1);
        tick();
        cd_valid_i = '0;
        cd_i       = '0;
        chk("A_idle", 64'(start_ready_o), 64'd1);
        chk("A_cd_ready_off", 64'(cd_ready_o), 64'd0);

        // Round B: all four CRs in one cycle, no data anywhere
        start_round(4'b1111);
        cr_valid_i = 4'b1111;
        #1;
        chk("B_cr_ready_all", 64'(cr_ready_o), 64'b1111);
        tick();
        cr_valid_i = '0;
        chk("B_one_cycle", 64'(result_valid_o), 64'd1);
        chk("B_result", 64'({data_avail_o, shared_o, dirty_o, error_o}), 64'd0);
        result_ready_i = 1'b1;
        cd_valid_i     = 4'b1111;
        #1;
        chk("B_no_cd", 64'(cd_ready_o), 64'd0);
        tick();
        result_ready_i = 1'b0;
        chk("B_idle", 64'(start_ready_o), 64'd1);
        chk("B_no_cd_idle", 64'(cd_ready_o | 4'(cd_handshake_o)), 64'd0);
        cd_valid_i = '0;

        // Round C: ports 1 and 3 dirty data; port1 forwarded, port3 drained
        start_round(4'b1010);
        cr_valid_i   = 4'b1010;
        cr_resp_i[1] = 5'b00101;
        cr_resp_i[3] = 5'b00101;
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        chk("C_result", 64'({data_avail_o, shared_o, dirty_o, error_o}), 64'b1010);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        chk("C_cd_ready", 64'(cd_ready_o), 64'b1010);
        cd_valid_i = 4'b1010;
        cd_i[1]    = '{data: 64'hB1, last: 1'b0};
        cd_i[3]    = '{data: 64'hD1, last: 1'b1};
        #1;
        chk("C_push1", 64'(cd_handshake_o), 64'd1);
        chk("C_data1", cd_o.data, 64'hB1);
        tick();
        cd_i[1] = '{data: 64'hB2, last: 1'b1};
        cd_i[3] = '{data: 64'hD2, last: 1'b1};
        #1;
        chk("C_drain_done", 64'(cd_ready_o), 64'b0010);
        chk("C_data2", cd_o.data, 64'hB2);
        tick();
        cd_valid_i = '0;
        cd_i       = '0;
        chk("C_idle", 64'(start_ready_o), 64'd1);

        // Round D: FIFO full for three cycles stalls the forwarded port
        start_round(4'b0001);
        cr_valid_i   = 4'b0001;
        cr_resp_i[0] = 5'b00001;
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        cd_fifo_full_i = 1'b1;
        cd_valid_i     = 4'b0001;
        cd_i[0]        = '{data: 64'hC1, last: 1'b0};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("D_stall", 64'({cd_ready_o[0], cd_handshake_o}), 64'd0);
            tick();
        end
        cd_fifo_full_i = 1'b0;
        #1;
        chk("D_push1", 64'(cd_handshake_o), 64'd1);
        chk("D_data1", cd_o.data, 64'hC1);
        tick();
        cd_i[0] = '{data: 64'hC2, last: 1'b1};
        #1;
        chk("D_push2", 64'(cd_handshake_o), 64'd1);
        chk("D_data2", cd_o.data, 64'hC2);
        tick();
        cd_valid_i = '0;
        cd_i       = '0;
        chk("D_idle", 64'(start_ready_o), 64'd1);

        // Round E: data with error is drained, nothing pushed
        start_round(4'b0001);
        cr_valid_i   = 4'b0001;
        cr_resp_i[0] = 5'b00011;
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        chk("E_result", 64'({data_avail_o, shared_o, dirty_o, error_o}), 64'b0001);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        chk("E_drain_ready", 64'(cd_ready_o), 64'b0001);
        cd_valid_i = 4'b0001;
        cd_i[0]    = '{data: 64'hE1, last: 1'b1};
        #1;
        chk("E_no_push", 64'(cd_handshake_o), 64'd0);
        tick();
        cd_valid_i = '0;
        cd_i       = '0;
        chk("E_idle", 64'(start_ready_o), 64'd1);

        // Round F: reset mid-forward abandons the round
        start_round(4'b0100);
        cr_valid_i   = 4'b0100;
        cr_resp_i[2] = 5'b00001;
        tick();
        cr_valid_i = '0;
        cr_resp_i  = '0;
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        cd_valid_i = 4'b0100;
        cd_i[2]    = '{data: 64'hF1, last: 1'b0};
        tick();
        chk("F_cnt_one", 64'(dut.beat_cnt_q), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("F_rst_idle", 64'(start_ready_o), 64'd1);
        chk("F_rst_outs", 64'({cd_ready_o, cd_handshake_o, result_valid_o, data_avail_o}), 64'd0);
        chk("F_rst_cnt", 64'(dut.beat_cnt_q), 64'd0);
        tick();
        rst_ni     = 1'b1;
        cd_valid_i = '0;
        cd_i       = '0;
        tick();

        // Round G: zero mask after reset passes straight through
        start_round(4'b0000);
        chk("G_collect_cr_ready", 64'(cr_ready_o), 64'd0);
        tick();
        chk("G_result_valid", 64'(result_valid_o), 64'd1);
        chk("G_result", 64'({data_avail_o, shared_o, dirty_o, error_o}), 64'd0);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        chk("G_idle", 64'(start_ready_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
